opcode_gen: RTL

OPCODE_GEN -- requirements
Module: opcode_gen

---
 rtl/opcode_pkg.sv | 15 +
 rtl/opcode_gen_if.sv | 22 ++
 rtl/opcode_gen.sv | 130 +++++++++++++
 3 files changed

// File: rtl/opcode_pkg.sv
// Shared framing constants and FSM encoding for the nibble opcode generator and its decoder.
package opcode_pkg;

    localparam logic [15:0] OPC_PREAMBLE     = 16'h55D5;
    localparam int          OPC_PRE_NIBBLES  = 4;
    localparam int          OPC_NIBBLES      = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

endpackage

// File: rtl/opcode_gen_if.sv
// Command-in / nibble-out bus of the opcode generator.
interface opcode_gen_if #(
    parameter int DIN_W  = 16,
    parameter int DOUT_W = 4
);
    logic [DIN_W-1:0]  din;
    logic              din_vld;
    logic              din_rdy;
    logic [DOUT_W-1:0] dout;
    logic              dout_vld;
    logic              busy;

    modport master (
        output din, din_vld,
        input  din_rdy, dout, dout_vld, busy
    );

    modport slave (
        input  din, din_vld,
        output din_rdy, dout, dout_vld, busy
    );
endinterface

// File: rtl/opcode_gen.sv
// Serialises each accepted command as preamble + payload nibbles, PERIOD cycles per slot,
// followed by GAP idle slots; a one-entry holding buffer lets the next command queue up.
module opcode_gen
    import opcode_pkg::*;
#(
    parameter int          DIN_W    = 16,
    parameter int          DOUT_W   = 4,
    parameter logic [15:0] PREAMBLE = OPC_PREAMBLE,
    parameter int          PERIOD   = 1,
    parameter int          GAP      = 2
) (
    input  logic        clk,
    input  logic        rst,
    opcode_gen_if.slave bus
);

    localparam int         SR_W      = 16 + DIN_W;
    localparam logic [7:0] SLOT_LAST = 8'(PERIOD - 1);
    localparam logic [3:0] GAP_LAST  = 4'(GAP - 1);
    localparam logic [2:0] PRE_LAST  = 3'(OPC_PRE_NIBBLES - 1);
    localparam logic [2:0] NIB_LAST  = 3'(OPC_NIBBLES - 1);
    localparam bit         NO_GAP    = (GAP == 0);

    state_t            state, state_nxt;
    logic [7:0]        cnt0;
    logic [2:0]        cnt1;
    logic [3:0]        gcnt;
    logic [SR_W-1:0]   sr;
    logic [DIN_W-1:0]  hold_q;
    logic              hold_full;
    logic [DOUT_W-1:0] dout_q, dout_d;
    logic              dout_vld_q, dout_vld_d;

    logic              slot_end, frame_end, gap_end;
    logic              load_pt, load, accept, nib_step;
    logic [DIN_W-1:0]  load_data;

    assign accept    = bus.din_vld && !hold_full;
    assign slot_end  = (cnt0 == SLOT_LAST);
    assign frame_end = (state == ST_DATA) && slot_end && (cnt1 == NIB_LAST);
    assign gap_end   = (state == ST_GAP) && slot_end && (gcnt == GAP_LAST);
    assign load_data = hold_full ? hold_q : bus.din;

    // A new frame may start only at a frame boundary; the buffered command wins, otherwise
    // a command accepted in that very cycle bypasses the buffer.
    always_comb begin
        load_pt = 1'b0;
        case (state)
            ST_IDLE: load_pt = 1'b1;
            ST_DATA: load_pt = frame_end && NO_GAP;
            ST_GAP:  load_pt = gap_end;
            default: load_pt = 1'b0;
        endcase
        load = load_pt && (hold_full || accept);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (load) state_nxt = ST_PRE;
            ST_PRE:  if (slot_end && cnt1 == PRE_LAST) state_nxt = ST_DATA;
            ST_DATA: begin
                if (frame_end) begin
                    if (!NO_GAP)   state_nxt = ST_GAP;
                    else if (load) state_nxt = ST_PRE;
                    else           state_nxt = ST_IDLE;
                end
            end
            ST_GAP:  if (gap_end) state_nxt = load ? ST_PRE : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        nib_step   = (state == ST_PRE || state == ST_DATA) && slot_end && !frame_end;
        dout_vld_d = load || nib_step;
        dout_d     = dout_q;
        if (load)          dout_d = PREAMBLE[15 -: DOUT_W];
        else if (nib_step) dout_d = sr[SR_W-1 -: DOUT_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0       <= '0;
            cnt1       <= '0;
            gcnt       <= '0;
            sr         <= '0;
            hold_q     <= '0;
            hold_full  <= 1'b0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
        end else begin
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;

            // The first preamble nibble goes straight to dout; sr keeps the remaining nibbles.
            if (load) begin
                cnt0 <= '0;
                cnt1 <= '0;
                sr   <= {PREAMBLE[15-DOUT_W:0], load_data, {DOUT_W{1'b0}}};
            end else begin
                if (state == ST_IDLE || slot_end) cnt0 <= '0;
                else                              cnt0 <= cnt0 + 8'd1;
                if (nib_step || frame_end) cnt1 <= cnt1 + 3'd1;
                if (nib_step)              sr   <= sr << DOUT_W;
            end

            if (state_nxt != ST_GAP)            gcnt <= '0;
            else if (state == ST_GAP && slot_end) gcnt <= gcnt + 4'd1;

            if (load) begin
                hold_full <= 1'b0;
            end else if (accept) begin
                hold_q    <= bus.din;
                hold_full <= 1'b1;
            end
        end
    end

    assign bus.dout     = dout_q;
    assign bus.dout_vld = dout_vld_q;
    assign bus.din_rdy  = !hold_full;
    assign bus.busy     = (state != ST_IDLE);

endmodule
